// File: rtl/plab3_mem_line_word_bridge.sv
// Bridges a 128-bit cache line port onto a 32-bit word memory: full lines become four word beats,
// sub-line requests a single beat. Define PLAB3_MEM_LINE_WORD_BRIDGE_CWF_EN for critical-word-first reads.
module plab3_mem_line_word_bridge #(
    parameter int unsigned abw = 32,
    parameter int unsigned dbw = 32,
    parameter int unsigned clw = 128
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   linereq_val,
    output logic                   linereq_rdy,
    input  logic [clw+abw+12:0]    linereq_msg,

    output logic                   lineresp_val,
    input  logic                   lineresp_rdy,
    output logic [clw+12:0]        lineresp_msg,

    output logic                   memreq_val,
    input  logic                   memreq_rdy,
    output logic [dbw+abw+10:0]    memreq_msg,

    input  logic                   memresp_val,
    output logic                   memresp_rdy,
    input  logic [dbw+10:0]        memresp_msg
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e           state_q;
    logic             typ_q;
    logic [7:0]       opaque_q;
    logic [abw-1:0]   addr_q;
    logic [3:0]       len_q;
    logic [clw-1:0]   line_q;
    logic             full_q;
    logic [2:0]       scnt_q;
    logic [2:0]       rcnt_q;
    logic [dbw-1:0]   wbuf_q [4];

    logic [2:0]       nbeats;
    logic [1:0]       idx;
    logic [abw-1:0]   beat_addr;
    logic [1:0]       beat_len;
    logic [dbw-1:0]   beat_data;
    logic [clw-1:0]   resp_data;
    logic             unused_memresp;

    assign nbeats       = full_q ? 3'd4 : 3'd1;
    assign linereq_rdy  = (state_q == StIdle);
    assign lineresp_val = (state_q == StResp);
    assign memreq_val   = (state_q == StBusy) && (scnt_q < nbeats);
    // Outside BUSY stray responses are accepted and dropped.
    assign memresp_rdy  = (state_q != StBusy) || (rcnt_q < nbeats);

    assign unused_memresp = ^{memresp_msg[dbw+10:dbw+4], memresp_msg[dbw+1:dbw]};

    always_comb begin
        idx = scnt_q[1:0];
`ifdef PLAB3_MEM_LINE_WORD_BRIDGE_CWF_EN
        // Full-line reads start at the requested word and wrap.
        if (full_q && !typ_q) begin
            idx = addr_q[3:2] + scnt_q[1:0];
        end
`endif
        beat_addr = addr_q;
        beat_len  = len_q[1:0];
        beat_data = line_q[dbw-1:0];
        if (full_q) begin
            beat_addr = {addr_q[abw-1:4], idx, 2'b00};
            beat_len  = 2'b00;
            beat_data = line_q[idx*dbw +: dbw];
        end
    end

    assign memreq_msg = {typ_q, 6'b0, idx, beat_addr, beat_len, beat_data};

    always_comb begin
        resp_data = '0;
        if (!typ_q) begin
            if (full_q) begin
                resp_data = {wbuf_q[3], wbuf_q[2], wbuf_q[1], wbuf_q[0]};
            end else begin
                resp_data[dbw-1:0] = wbuf_q[0];
            end
        end
    end

    assign lineresp_msg = {typ_q, opaque_q, len_q, resp_data};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            typ_q    <= 1'b0;
            opaque_q <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            line_q   <= '0;
            full_q   <= 1'b0;
            scnt_q   <= '0;
            rcnt_q   <= '0;
            for (int i = 0; i < 4; i++) begin
                wbuf_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (linereq_val) begin
                        typ_q    <= linereq_msg[clw+abw+12];
                        opaque_q <= linereq_msg[clw+abw+11:clw+abw+4];
                        addr_q   <= linereq_msg[clw+abw+3:clw+4];
                        len_q    <= linereq_msg[clw+3:clw];
                        line_q   <= linereq_msg[clw-1:0];
                        full_q   <= (linereq_msg[clw+3:clw] == 4'd0);
                        scnt_q   <= '0;
                        rcnt_q   <= '0;
                        state_q  <= StBusy;
                    end
                end
                StBusy: begin
                    if (memreq_val && memreq_rdy) begin
                        scnt_q <= scnt_q + 3'd1;
                    end
                    if (memresp_val && memresp_rdy) begin
                        wbuf_q[memresp_msg[dbw+3:dbw+2]] <= memresp_msg[dbw-1:0];
                        rcnt_q <= rcnt_q + 3'd1;
                        if (rcnt_q + 3'd1 == nbeats) begin
                            state_q <= StResp;
                        end
                    end
                end
                StResp: begin
                    if (lineresp_rdy) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_plab3_mem_line_word_bridge.sv
// Directed bench for plab3_mem_line_word_bridge with a word-memory model that can stall and
// return responses out of order.
module tb_plab3_mem_line_word_bridge;

    logic          clk = 1'b0;
    logic          reset;
    logic          linereq_val;
    logic          linereq_rdy;
    logic [172:0]  linereq_msg;
    logic          lineresp_val;
    logic          lineresp_rdy;
    logic [140:0]  lineresp_msg;
    logic          memreq_val;
    logic          memreq_rdy;
    logic [74:0]   memreq_msg;
    logic          memresp_val;
    logic          memresp_rdy;
    logic [42:0]   memresp_msg;

    always #5 clk = ~clk;

    plab3_mem_line_word_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .linereq_val  (linereq_val),
        .linereq_rdy  (linereq_rdy),
        .linereq_msg  (linereq_msg),
        .lineresp_val (lineresp_val),
        .lineresp_rdy (lineresp_rdy),
        .lineresp_msg (lineresp_msg),
        .memreq_val   (memreq_val),
        .memreq_rdy   (memreq_rdy),
        .memreq_msg   (memreq_msg),
        .memresp_val  (memresp_val),
        .memresp_rdy  (memresp_rdy),
        .memresp_msg  (memresp_msg)
    );

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   mem [logic [31:0]];
    logic [74:0]   pend [$];
    logic [74:0]   mlog [$];
    int            ord [$];
    int            resp_idx = -1;
    bit            stall_mode = 0;
    bit            reorder_mode = 0;
    bit            got;
    logic [140:0]  got_resp;
    int            cyc;

    task automatic check_eq(input string tag, input logic [159:0] got_v, input logic [159:0] exp_v);
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got_v, exp_v);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Called at a negedge: records the handshakes of the coming edge, then drives the next cycle.
    task automatic cycle();
        bit           req_f, resp_f, lreq_f, lresp_f, mreq_stall, lresp_stall, found;
        logic [74:0]  mreq;
        logic [74:0]  p;
        logic [140:0] lresp;
        logic [1:0]   want;
        req_f       = memreq_val && memreq_rdy;
        resp_f      = memresp_val && memresp_rdy;
        lreq_f      = linereq_val && linereq_rdy;
        lresp_f     = lineresp_val && lineresp_rdy;
        mreq_stall  = memreq_val && !memreq_rdy;
        lresp_stall = lineresp_val && !lineresp_rdy;
        mreq        = memreq_msg;
        lresp       = lineresp_msg;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (lreq_f) linereq_val = 1'b0;
        if (req_f) begin
            pend.push_back(mreq);
            mlog.push_back(mreq);
            if (mreq[74]) mem[mreq[65:34]] = mreq[31:0];
        end
        if (resp_f && resp_idx >= 0) begin
            pend.delete(resp_idx);
            if (reorder_mode && ord.size() > 0) ord.delete(0);
        end
        if (lresp_f) begin
            got      = 1'b1;
            got_resp = lresp;
        end
        if (mreq_stall) check_eq("memreq_hold", {memreq_val, memreq_msg}, {1'b1, mreq});
        if (lresp_stall) check_eq("lineresp_hold", {lineresp_val, lineresp_msg}, {1'b1, lresp});
        memreq_rdy   = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        lineresp_rdy = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        resp_idx = -1;
        found    = 1'b0;
        want     = (ord.size() > 0) ? 2'(ord[0]) : 2'd0;
        for (int i = 0; i < pend.size(); i++) begin
            p = pend[i];
            if (!found && (!reorder_mode || (ord.size() > 0 && p[67:66] == want))) begin
                found    = 1'b1;
                resp_idx = i;
            end
        end
        if (found) begin
            p           = pend[resp_idx];
            memresp_val = 1'b1;
            memresp_msg = {p[74], p[73:66], p[33:32], p[74] ? 32'h0 : rd(p[65:34])};
        end else begin
            memresp_val = 1'b0;
            memresp_msg = '0;
        end
    endtask

    task automatic do_line(input logic typ, input logic [7:0] opq, input logic [31:0] addr,
                           input logic [3:0] len, input logic [127:0] data,
                           output logic [140:0] resp, output int lat, output int first_req);
        mlog.delete();
        got       = 1'b0;
        lat       = -1;
        first_req = -1;
        cyc       = 0;
        linereq_msg = {typ, opq, addr, len, data};
        linereq_val = 1'b1;
        cycle();
        while (!got && cyc < 400) begin
            if (memreq_val && first_req < 0) first_req = cyc;
            if (lineresp_val && lat < 0) lat = cyc;
            cycle();
        end
        check_eq("lineresp_done", {159'd0, got}, 160'd1);
        resp = got_resp;
    endtask

    logic [140:0] resp;
    int           lat;
    int           first_req;
    logic [74:0]  m;
    logic [31:0]  exp_addr [4];

    initial begin
        reset        = 1'b1;
        linereq_val  = 1'b0;
        linereq_msg  = '0;
        lineresp_rdy = 1'b1;
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b0;
        memresp_msg  = '0;
        mem[32'h1000] = 32'h11;        mem[32'h1004] = 32'h22;
        mem[32'h1008] = 32'h33;        mem[32'h100C] = 32'h44;
        mem[32'h3004] = 32'hCAFE_F00D;
        mem[32'h5000] = 32'h0A0A_0A0A; mem[32'h5004] = 32'h1B1B_1B1B;
        mem[32'h5008] = 32'h2C2C_2C2C; mem[32'h500C] = 32'h3D3D_3D3D;
        mem[32'h4000] = 32'h4000_0001; mem[32'h4004] = 32'h4000_0002;
        mem[32'h4008] = 32'h4000_0003; mem[32'h400C] = 32'h4000_0004;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_linereq_rdy", {159'd0, linereq_rdy}, 160'd1);
        check_eq("rst_lineresp_val", {159'd0, lineresp_val}, 160'd0);
        check_eq("rst_memreq_val", {159'd0, memreq_val}, 160'd0);
        check_eq("rst_memresp_rdy", {159'd0, memresp_rdy}, 160'd1);

        // Full-line read, zero-wait memory
        do_line(1'b0, 8'h2A, 32'h1000, 4'd0, 128'h0, resp, lat, first_req);
        check_eq("rd_first_req", 160'(first_req), 160'd1);
        check_eq("rd_latency", 160'(lat), 160'd6);
        check_eq("rd_nbeats", 160'(mlog.size()), 160'd4);
        for (int i = 0; i < 4 && i < mlog.size(); i++) begin
            m = mlog[i];
            check_eq("rd_addr", 160'(m[65:34]), 160'(32'h1000 + 32'(4 * i)));
            check_eq("rd_opq", 160'(m[73:66]), 160'(i));
            check_eq("rd_len", 160'(m[33:32]), 160'd0);
        end
        check_eq("rd_resp_type", 160'(resp[140]), 160'd0);
        check_eq("rd_resp_opq", 160'(resp[139:132]), 160'h2A);
        check_eq("rd_resp_len", 160'(resp[131:128]), 160'd0);
        check_eq("rd_resp_data", 160'(resp[127:0]),
                 160'(128'h00000044_00000033_00000022_00000011));

        // Full-line write
        do_line(1'b1, 8'h05, 32'h2000, 4'd0,
                128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA, resp, lat, first_req);
        check_eq("wr_nbeats", 160'(mlog.size()), 160'd4);
        for (int i = 0; i < 4 && i < mlog.size(); i++) begin
            m = mlog[i];
            check_eq("wr_type", 160'(m[74]), 160'd1);
        end
        check_eq("wr_mem0", 160'(rd(32'h2000)), 160'h0000AAAA);
        check_eq("wr_mem1", 160'(rd(32'h2004)), 160'h0000BBBB);
        check_eq("wr_mem2", 160'(rd(32'h2008)), 160'h0000CCCC);
        check_eq("wr_mem3", 160'(rd(32'h200C)), 160'h0000DDDD);
        check_eq("wr_resp_type", 160'(resp[140]), 160'd1);
        check_eq("wr_resp_opq", 160'(resp[139:132]), 160'h05);
        check_eq("wr_resp_data", 160'(resp[127:0]), 160'd0);

        // Single-beat read, len 4
        do_line(1'b0, 8'h07, 32'h3004, 4'd4, 128'h0, resp, lat, first_req);
        check_eq("sb_nbeats", 160'(mlog.size()), 160'd1);
        if (mlog.size() > 0) begin
            m = mlog[0];
            check_eq("sb_addr", 160'(m[65:34]), 160'h3004);
            check_eq("sb_len", 160'(m[33:32]), 160'd0);
        end
        check_eq("sb_latency", 160'(lat), 160'd3);
        check_eq("sb_resp_len", 160'(resp[131:128]), 160'd4);
        check_eq("sb_resp_data", 160'(resp[127:0]), 160'(128'hCAFE_F00D));

        // Backpressure with out-of-order responses
        stall_mode   = 1'b1;
        reorder_mode = 1'b1;
        ord          = '{3, 1, 0, 2};
        do_line(1'b0, 8'h33, 32'h5000, 4'd0, 128'h0, resp, lat, first_req);
        stall_mode   = 1'b0;
        reorder_mode = 1'b0;
        memreq_rdy   = 1'b1;
        lineresp_rdy = 1'b1;
        check_eq("ro_nbeats", 160'(mlog.size()), 160'd4);
        check_eq("ro_resp_opq", 160'(resp[139:132]), 160'h33);
        check_eq("ro_resp_data", 160'(resp[127:0]),
                 160'(128'h3D3D3D3D_2C2C2C2C_1B1B1B1B_0A0A0A0A));

        // Read at the last word of a line: beat order depends on critical-word-first
`ifdef PLAB3_MEM_LINE_WORD_BRIDGE_CWF_EN
        exp_addr = '{32'h400C, 32'h4000, 32'h4004, 32'h4008};
`else
        exp_addr = '{32'h4000, 32'h4004, 32'h4008, 32'h400C};
`endif
        do_line(1'b0, 8'h44, 32'h400C, 4'd0, 128'h0, resp, lat, first_req);
        check_eq("cw_nbeats", 160'(mlog.size()), 160'd4);
        for (int i = 0; i < 4 && i < mlog.size(); i++) begin
            m = mlog[i];
            check_eq("cw_addr", 160'(m[65:34]), 160'(exp_addr[i]));
        end
        check_eq("cw_resp_data", 160'(resp[127:0]),
                 160'(128'h40000004_40000003_40000002_40000001));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
